// File: rtl/nand_cpu_pkg.sv
// Shared CPU package: checkpoint sizing, tag type and slot layout.
// NUM_D_REG / NUM_S_REG come from the CPU-wide header when it is compiled
// first. Otherwise they fall back to the local defaults below.
`ifndef NUM_D_REG
`define NUM_D_REG 16
`endif
`ifndef NUM_S_REG
`define NUM_S_REG 8
`endif

package nand_cpu_pkg;
    localparam int NUM_CP = 4;
    localparam int NUM_D  = `NUM_D_REG;
    localparam int NUM_S  = `NUM_S_REG;

    typedef logic [$clog2(NUM_CP)-1:0] cp_tag_t;

    typedef struct packed {
        logic             valid;
        logic             done;
        logic [NUM_D-1:0] r_snap;
        logic [NUM_S-1:0] s_snap;
    } cp_slot_t;
endpackage

// File: rtl/frl_checkpoint.sv
// Checkpoint-to-free-list interface.
// - modport out: producer side (checkpoint unit) drives restore and the restored lists.
// - modport in:  free register list side consumes them.
interface frl_checkpoint #(
    parameter int NUM_D = nand_cpu_pkg::NUM_D,
    parameter int NUM_S = nand_cpu_pkg::NUM_S
);
    logic             restore;
    logic [NUM_D-1:0] r_free_list;
    logic [NUM_S-1:0] s_free_list;

    modport out (output restore, output r_free_list, output s_free_list);
    modport in  (input  restore, input  r_free_list, input  s_free_list);
endinterface

// File: rtl/cp_snapshot_merge.sv
// Produces the next-state view of a free list vector.
// - The checked-out register bit is cleared first.
// - The returned register bit is then set.
// Ports:
//   free_in          current registered free list
//   co, co_addr      register checked out this cycle
//   ret, ret_addr    register returned by commit this cycle
//   free_out         edited free list
module cp_snapshot_merge
    import nand_cpu_pkg::*;
#(
    parameter int W  = 16,
    parameter int AW = $clog2(W)
) (
    input  logic [W-1:0]  free_in,
    input  logic          co,
    input  logic [AW-1:0] co_addr,
    input  logic          ret,
    input  logic [AW-1:0] ret_addr,
    output logic [W-1:0]  free_out
);
    always_comb begin
        free_out = free_in;
        if (co)
            free_out[co_addr] = 1'b0;
        // A return wins over a checkout of the same register.
        if (ret)
            free_out[ret_addr] = 1'b1;
    end
endmodule

// File: rtl/frl_checkpoint_unit.sv
// Free-register-list checkpoint unit.
// - Snapshots the general (D) and status (S) free lists on every dispatched branch.
// - Keeps live snapshots current with commit returns.
// - Drives a zero-latency restore on a mispredict.
// Ports:
//   clk, n_rst                   clock, async active-low reset
//   alloc                        branch dispatched, take a snapshot
//   cur_r_free, cur_s_free       current registered free lists
//   co_r/co_r_addr, co_s/...     registers checked out this cycle
//   ret_r/ret_r_addr, ret_s/...  registers returned by commit this cycle
//   resolve, resolve_tag         branch resolved and its checkpoint tag
//   mispredict                   qualifies resolve
//   alloc_tag                    tag given to this cycle's snapshot
//   full                         no free slot
//   restore, r_free_list, s_free_list   restore request to the free list
module frl_checkpoint_unit #(
    parameter int NUM_CP = nand_cpu_pkg::NUM_CP,
    parameter int NUM_D  = nand_cpu_pkg::NUM_D,
    parameter int NUM_S  = nand_cpu_pkg::NUM_S
) (
    input  logic                      clk,
    input  logic                      n_rst,
    input  logic                      alloc,
    input  logic [NUM_D-1:0]          cur_r_free,
    input  logic [NUM_S-1:0]          cur_s_free,
    input  logic                      co_r,
    input  logic [$clog2(NUM_D)-1:0]  co_r_addr,
    input  logic                      co_s,
    input  logic [$clog2(NUM_S)-1:0]  co_s_addr,
    input  logic                      ret_r,
    input  logic [$clog2(NUM_D)-1:0]  ret_r_addr,
    input  logic                      ret_s,
    input  logic [$clog2(NUM_S)-1:0]  ret_s_addr,
    input  logic                      resolve,
    input  logic [$clog2(NUM_CP)-1:0] resolve_tag,
    input  logic                      mispredict,
    output logic [$clog2(NUM_CP)-1:0] alloc_tag,
    output logic                      full,
    output logic                      restore,
    output logic [NUM_D-1:0]          r_free_list,
    output logic [NUM_S-1:0]          s_free_list
);
    import nand_cpu_pkg::*;

    localparam int TW = $clog2(NUM_CP);
    localparam int CW = $clog2(NUM_CP + 1);

    logic [NUM_CP-1:0] valid, done;
    logic [NUM_CP-1:0] valid_next, done_next, kill;
    logic [NUM_D-1:0]  r_snap [NUM_CP];
    logic [NUM_S-1:0]  s_snap [NUM_CP];
    logic [TW-1:0]     head, tail, head_next, tag_dist;
    logic [CW-1:0]     count;

    logic              mis_fire, ok_fire, do_alloc, retire;
    logic [NUM_D-1:0]  r_merged, r_ret_mask;
    logic [NUM_S-1:0]  s_merged, s_ret_mask;

    frl_checkpoint #(.NUM_D(NUM_D), .NUM_S(NUM_S)) cp_if ();

    cp_snapshot_merge #(.W(NUM_D)) u_merge_d (
        .free_in (cur_r_free),
        .co      (co_r),
        .co_addr (co_r_addr),
        .ret     (ret_r),
        .ret_addr(ret_r_addr),
        .free_out(r_merged)
    );

    cp_snapshot_merge #(.W(NUM_S)) u_merge_s (
        .free_in (cur_s_free),
        .co      (co_s),
        .co_addr (co_s_addr),
        .ret     (ret_s),
        .ret_addr(ret_s_addr),
        .free_out(s_merged)
    );

    always_comb begin
        r_ret_mask = '0;
        s_ret_mask = '0;
        if (ret_r)
            r_ret_mask[ret_r_addr] = 1'b1;
        if (ret_s)
            s_ret_mask[ret_s_addr] = 1'b1;
    end

    assign full      = (count == CW'(NUM_CP));
    assign alloc_tag = tail;
    assign mis_fire  = resolve & mispredict & valid[resolve_tag];
    assign ok_fire   = resolve & ~mispredict & valid[resolve_tag];
    // The dispatching branch is younger than any mispredicting one, so it is squashed.
    assign do_alloc  = alloc & ~full & ~mis_fire;
    // The head cannot retire in the same cycle that it is flushed.
    assign retire    = valid[head] & done[head] & ~(mis_fire & (resolve_tag == head));
    assign head_next = retire ? head + TW'(1) : head;
    assign tag_dist  = resolve_tag - head;

    always_comb begin
        valid_next = valid;
        done_next  = done;
        kill       = '0;
        for (int i = 0; i < NUM_CP; i++) begin
            // Age order is distance from head. The resolved slot and everything younger are flushed.
            kill[i] = mis_fire && (TW'(TW'(i) - head) >= tag_dist);
            if (kill[i] || (retire && TW'(i) == head)) begin
                valid_next[i] = 1'b0;
                done_next[i]  = 1'b0;
            end else begin
                if (do_alloc && TW'(i) == tail) begin
                    valid_next[i] = 1'b1;
                    done_next[i]  = 1'b0;
                end
                if (ok_fire && TW'(i) == resolve_tag)
                    done_next[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            valid <= '0;
            done  <= '0;
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            valid <= valid_next;
            done  <= done_next;
            head  <= head_next;
            if (mis_fire) begin
                tail  <= resolve_tag;
                count <= CW'(TW'(resolve_tag - head_next));
            end else begin
                if (do_alloc)
                    tail <= tail + TW'(1);
                count <= count + CW'(do_alloc) - CW'(retire);
            end
        end
    end

    // Snapshot payload carries no reset: valid alone decides whether it is meaningful.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CP; i++) begin
            if (do_alloc && TW'(i) == tail) begin
                r_snap[i] <= r_merged;
                s_snap[i] <= s_merged;
            end else if (valid[i]) begin
                r_snap[i] <= r_snap[i] | r_ret_mask;
                s_snap[i] <= s_snap[i] | s_ret_mask;
            end
        end
    end

    // The restore path is combinational: the free list loads it on the same edge.
    assign cp_if.restore     = mis_fire;
    assign cp_if.r_free_list = mis_fire ? (r_snap[resolve_tag] | r_ret_mask) : '1;
    assign cp_if.s_free_list = mis_fire ? (s_snap[resolve_tag] | s_ret_mask) : '1;

    assign restore     = cp_if.restore;
    assign r_free_list = cp_if.r_free_list;
    assign s_free_list = cp_if.s_free_list;
endmodule

// File: tb/tb_frl_checkpoint_unit.sv
// Directed bench for frl_checkpoint_unit (NUM_CP=4, NUM_D=16, NUM_S=8).
module tb_frl_checkpoint_unit;
    logic        clk = 1'b0;
    logic        n_rst;
    logic        alloc;
    logic [15:0] cur_r_free;
    logic [7:0]  cur_s_free;
    logic        co_r, co_s, ret_r, ret_s;
    logic [3:0]  co_r_addr, ret_r_addr;
    logic [2:0]  co_s_addr, ret_s_addr;
    logic        resolve, mispredict;
    logic [1:0]  resolve_tag;
    logic [1:0]  alloc_tag;
    logic        full, restore;
    logic [15:0] r_free_list;
    logic [7:0]  s_free_list;

    int vectors = 0;
    int miscompares = 0;

    frl_checkpoint_unit #(.NUM_CP(4), .NUM_D(16), .NUM_S(8)) dut (
        .clk(clk), .n_rst(n_rst), .alloc(alloc),
        .cur_r_free(cur_r_free), .cur_s_free(cur_s_free),
        .co_r(co_r), .co_r_addr(co_r_addr), .co_s(co_s), .co_s_addr(co_s_addr),
        .ret_r(ret_r), .ret_r_addr(ret_r_addr), .ret_s(ret_s), .ret_s_addr(ret_s_addr),
        .resolve(resolve), .resolve_tag(resolve_tag), .mispredict(mispredict),
        .alloc_tag(alloc_tag), .full(full), .restore(restore),
        .r_free_list(r_free_list), .s_free_list(s_free_list)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_in();
        alloc = 0; cur_r_free = '0; cur_s_free = '0;
        co_r = 0; co_r_addr = '0; co_s = 0; co_s_addr = '0;
        ret_r = 0; ret_r_addr = '0; ret_s = 0; ret_s_addr = '0;
        resolve = 0; mispredict = 0; resolve_tag = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mis(input logic [1:0] tag);
        resolve = 1; mispredict = 1; resolve_tag = tag;
    endtask

    initial begin
        n_rst = 0;
        clear_in();
        #2;
        check("rst_restore", restore, 0);
        check("rst_full", full, 0);
        check("rst_tag", alloc_tag, 0);
        check("rst_rlist", r_free_list, 16'hFFFF);
        check("rst_slist", s_free_list, 8'hFF);
        n_rst = 1;
        tick();

        // Fill to full, then a fifth alloc is ignored
        for (int i = 0; i < 4; i++) begin
            clear_in();
            alloc = 1; cur_r_free = 16'h0001 << i; cur_s_free = 8'h10 << i;
            #1;
            check("fill_tag", alloc_tag, i);
            check("fill_notfull", full, 0);
            tick();
        end
        clear_in(); #1;
        check("fill_full", full, 1);
        alloc = 1; cur_r_free = 16'hBEEF; cur_s_free = 8'hAA; #1;
        check("full_tag", alloc_tag, 0);
        tick(); clear_in(); #1;
        check("full_stays", full, 1);
        check("full_tag_stays", alloc_tag, 0);
        mis(2'd0); #1;
        check("slot0_restore", restore, 1);
        check("slot0_r", r_free_list, 16'h0001);
        check("slot0_s", s_free_list, 8'h10);
        tick(); clear_in(); #1;
        check("flush_all_full", full, 0);
        check("flush_all_tag", alloc_tag, 0);
        check("flush_all_restore", restore, 0);

        // Snapshot edits
        alloc = 1; cur_r_free = 16'h00F0; co_r = 1; co_r_addr = 4; ret_r = 1; ret_r_addr = 9;
        cur_s_free = 8'h0F; co_s = 1; co_s_addr = 0; ret_s = 1; ret_s_addr = 7; #1;
        check("edit_tag", alloc_tag, 0);
        tick(); clear_in();
        ret_r = 1; ret_r_addr = 1; ret_s = 1; ret_s_addr = 4;
        tick(); clear_in();
        mis(2'd0); #1;
        check("edit_restore", restore, 1);
        check("edit_r", r_free_list, 16'h02E2);
        check("edit_s", s_free_list, 8'h9E);
        ret_r = 1; ret_r_addr = 15; #1;
        check("edit_r_ret_or", r_free_list, 16'h82E2);
        tick(); clear_in(); #1;
        check("edit_empty_tag", alloc_tag, 0);

        // Out-of-order correct resolve
        for (int i = 0; i < 3; i++) begin
            clear_in();
            alloc = 1; cur_r_free = 16'h0100 << i; #1;
            check("ooo_tag", alloc_tag, i);
            tick();
        end
        clear_in();
        resolve = 1; resolve_tag = 1; #1;
        check("ooo_no_restore", restore, 0);
        check("ooo_rlist_idle", r_free_list, 16'hFFFF);
        tick(); clear_in(); #1;
        check("ooo_tail", alloc_tag, 3);
        resolve = 1; resolve_tag = 0;
        tick(); clear_in();
        tick(); tick();
        // head should now be 2 with one live slot: three more allocs fill it
        for (int i = 0; i < 3; i++) begin
            clear_in();
            alloc = 1; cur_r_free = 16'hA000 | 16'(i); cur_s_free = 8'(i + 1); #1;
            check("ooo_fill_tag", alloc_tag, (3 + i) % 4);
            tick(); clear_in(); #1;
            check("ooo_fill_full", full, (i == 2));
        end

        // Mispredict flush of tag 3 (slots 3,0,1 squashed, slot 2 remains)
        mis(2'd3); #1;
        check("flush_restore", restore, 1);
        check("flush_r", r_free_list, 16'hA000);
        check("flush_s", s_free_list, 8'h01);
        tick(); clear_in(); #1;
        check("flush_tail", alloc_tag, 3);
        check("flush_full", full, 0);
        mis(2'd0); #1;
        check("inv_tag0", restore, 0);
        check("inv_tag0_r", r_free_list, 16'hFFFF);
        resolve_tag = 1; #1;
        check("inv_tag1", restore, 0);
        tick(); clear_in();
        for (int i = 0; i < 3; i++) begin
            clear_in();
            alloc = 1; #1;
            check("refill_tag", alloc_tag, (3 + i) % 4);
            tick(); clear_in(); #1;
            check("refill_full", full, (i == 2));
        end
        mis(2'd2); #1;
        check("head_restore", restore, 1);
        check("head_r", r_free_list, 16'h0400);
        tick(); clear_in(); #1;
        check("head_empty_full", full, 0);
        check("head_empty_tag", alloc_tag, 2);

        // Same-cycle alloc and mispredict
        alloc = 1; cur_r_free = 16'h1234; #1;
        check("same_first_tag", alloc_tag, 2);
        tick(); clear_in();
        alloc = 1; cur_r_free = 16'h5678; mis(2'd2); #1;
        check("same_restore", restore, 1);
        check("same_r", r_free_list, 16'h1234);
        tick(); clear_in(); #1;
        check("same_tag", alloc_tag, 2);
        check("same_full", full, 0);
        mis(2'd2); #1;
        check("same_inv_restore", restore, 0);
        tick(); clear_in();

        // Asynchronous reset mid-run while a restore is active
        for (int i = 0; i < 4; i++) begin
            clear_in(); alloc = 1; tick();
        end
        clear_in(); #1;
        check("pre_rst_full", full, 1);
        mis(2'd2); #1;
        check("pre_rst_restore", restore, 1);
        n_rst = 0; #1;
        check("async_restore", restore, 0);
        check("async_full", full, 0);
        check("async_tag", alloc_tag, 0);
        check("async_r", r_free_list, 16'hFFFF);
        tick(); clear_in();
        n_rst = 1;
        tick(); #1;
        check("post_rst_tag", alloc_tag, 0);
        check("post_rst_full", full, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
